// File: rtl/spi_prog_write.sv
// spi_prog_write: flash page-program command sequencer.
// On a matching command strobe it latches address/length, clips the burst so it
// never crosses a flash page, asks the SPI engine for a transfer, then streams
// opcode, address (MSB first) and the upstream data bytes into the engine.
// Ports:
//   clock, rst                  - single clock, synchronous active-high reset
//   cmd_request/cmd_code        - command strobe and selector
//   cmd_busy/cmd_finish         - this block's bit of the shared busy/finish vectors
//   wr_addr/wr_len/eff_len      - requested address/length, length actually programmed
//   spi_request/spi_busy        - engine handshake
//   spi_clk_en                  - engine byte-slot enable
//   spi_req_len/spi_req_wr_len  - transfer lengths in SPI clocks
//   spi_req_cmd                 - engine command (always 0)
//   spi_wr_vld/ready/data       - byte stream to engine
//   up_valid/up_data/up_ready   - upstream data stream
//   underrun                    - one-cycle pulse when the engine stops early
module spi_prog_write #(
  parameter int          MODULE_ID  = 0,
  parameter int          CMD        = 0,
  parameter int          DSIZE      = 8,
  parameter int          ADDR_BYTES = 3,
  parameter int          MAX_BURST  = 256,
  parameter int          PAGE_SIZE  = 256,
  parameter logic [7:0]  PRG_CMD_3B = 8'h02,
  parameter logic [7:0]  PRG_CMD_4B = 8'h12,
  parameter int          SSIZE      = 1
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         cmd_request,
  input  logic [7:0]                   cmd_code,
  output logic                         cmd_busy,
  output logic                         cmd_finish,
  input  logic [31:0]                  wr_addr,
  input  logic [$clog2(MAX_BURST):0]   wr_len,
  output logic [$clog2(MAX_BURST):0]   eff_len,
  output logic                         spi_request,
  input  logic                         spi_busy,
  input  logic                         spi_clk_en,
  output logic [23:0]                  spi_req_len,
  output logic [23:0]                  spi_req_wr_len,
  output logic [1:0]                   spi_req_cmd,
  output logic                         spi_wr_vld,
  input  logic                         spi_wr_ready,
  output logic [DSIZE-1:0]             spi_wr_data,
  input  logic                         up_valid,
  input  logic [DSIZE-1:0]             up_data,
  output logic                         up_ready,
  output logic                         underrun
);
  localparam int          LW   = $clog2(MAX_BURST) + 1;
  localparam int          SW   = LW + 3;             // header + data byte count
  localparam int          HB   = 1 + ADDR_BYTES;     // opcode + address bytes
  localparam logic [31:0] PS   = 32'(PAGE_SIZE);
  localparam logic [31:0] MB   = 32'(MAX_BURST);
  localparam logic [31:0] HB32 = 32'(HB);
  localparam logic [31:0] SS32 = 32'(SSIZE);
  localparam logic [7:0]  OPC  = (ADDR_BYTES == 4) ? PRG_CMD_4B : PRG_CMD_3B;
  // MODULE_ID only picks the vector bit outside this block; guard against bad values.
  localparam bit          ID_OK = (MODULE_ID >= 0);

  typedef enum logic [2:0] {IDLE, LATCH, EX_REQ, EXEC, DRAIN, FSH} state_t;

  state_t           state_q;
  logic [31:0]      addr_q;
  logic [LW-1:0]    len_q, eff_q, fetch_q;
  logic [SW-1:0]    send_q;
  logic [23:0]      rlen_q;
  logic [2:0]       hidx_q;
  logic             ovld_q;
  logic [DSIZE-1:0] odata_q;

  // Burst clamp and page clip, evaluated in LATCH.
  logic [31:0]   len_c, room_c, eff_c, rlen_c;
  logic [LW-1:0] eff_d;
  logic [23:0]   rlen_d;
  always_comb begin
    len_c = 32'(len_q);
    if (len_q == '0 || len_c > MB) len_c = MB;
    room_c = PS - (addr_q & (PS - 32'd1));
    eff_c  = (len_c < room_c) ? len_c : room_c;
    rlen_c = ((HB32 + eff_c) << 3) / SS32;
    eff_d  = LW'(eff_c);
    rlen_d = 24'(rlen_c);
  end

  // Header byte hidx_q: 0 is the opcode, 1..ADDR_BYTES walk the address MSB first.
  logic [7:0] hbyte;
  always_comb begin
    hbyte = OPC;
    if (hidx_q != 3'd0) hbyte = 8'(addr_q >> {3'(ADDR_BYTES) - hidx_q, 3'b000});
  end

  logic in_exec, hdr_pend, xfer, slot, up_rdy, up_fire, last, urun;
  always_comb begin
    in_exec  = (state_q == EXEC);
    hdr_pend = (hidx_q < 3'(HB));
    xfer     = in_exec && ovld_q && spi_wr_ready && spi_clk_en;
    slot     = in_exec && (!ovld_q || xfer);   // register free at the next edge
    up_rdy   = slot && !hdr_pend && (fetch_q != '0);
    up_fire  = up_rdy && up_valid;
    last     = xfer && (send_q == SW'(1));
    // A transfer finishing together with busy dropping still counts as complete.
    urun     = in_exec && !spi_busy && !last;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      len_q   <= '0;
      eff_q   <= '0;
      fetch_q <= '0;
      send_q  <= '0;
      rlen_q  <= '0;
      hidx_q  <= '0;
      ovld_q  <= 1'b0;
      odata_q <= '0;
    end else begin
      case (state_q)
        IDLE: if (cmd_request && ID_OK && cmd_code == 8'(CMD)) begin
          addr_q  <= wr_addr;
          len_q   <= wr_len;
          state_q <= LATCH;
        end
        LATCH: begin
          eff_q   <= eff_d;
          rlen_q  <= rlen_d;
          fetch_q <= eff_d;
          send_q  <= SW'(HB) + SW'(eff_d);
          hidx_q  <= '0;
          ovld_q  <= 1'b0;
          state_q <= EX_REQ;
        end
        EX_REQ: if (spi_busy) state_q <= EXEC;
        EXEC: begin
          if (urun) begin
            ovld_q  <= 1'b0;
            odata_q <= '0;
            state_q <= FSH;
          end else begin
            if (slot && hdr_pend) begin
              ovld_q  <= 1'b1;
              odata_q <= DSIZE'(hbyte);
              hidx_q  <= hidx_q + 3'd1;
            end else if (up_fire) begin
              ovld_q  <= 1'b1;
              odata_q <= up_data;
              fetch_q <= fetch_q - LW'(1);
            end else if (xfer) begin
              ovld_q  <= 1'b0;
              odata_q <= '0;
            end
            if (xfer) send_q <= send_q - SW'(1);
            if (last) state_q <= DRAIN;
          end
        end
        DRAIN: if (!spi_busy) state_q <= FSH;
        FSH:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Reset forces every output low immediately, not only after the next edge.
  assign cmd_busy       = !rst && (state_q == LATCH || state_q == EX_REQ ||
                                   state_q == EXEC  || state_q == DRAIN);
  assign cmd_finish     = !rst && (state_q == FSH);
  assign spi_request    = !rst && (state_q == EX_REQ);
  assign spi_wr_vld     = !rst && ovld_q;
  assign spi_wr_data    = spi_wr_vld ? odata_q : '0;
  assign up_ready       = !rst && up_rdy;
  assign underrun       = !rst && urun;
  assign eff_len        = rst ? '0 : eff_q;
  assign spi_req_len    = rst ? '0 : rlen_q;
  assign spi_req_wr_len = rst ? '0 : rlen_q;
  assign spi_req_cmd    = 2'b00;
endmodule

// File: tb/tb_spi_prog_write.sv
module tb_spi_prog_write;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_request;
  logic [7:0]  cmd_code;
  logic [31:0] wr_addr;
  logic [8:0]  wr_len;
  logic        spi_busy, spi_clk_en, spi_wr_ready, up_valid;
  logic [7:0]  up_data;

  // dut0: 3 address bytes, 1 lane, CMD 0.  dut1: 4 address bytes, 4 lanes, CMD 1.
  logic        a_busy, a_fin, a_req, a_vld, a_urdy, a_urun;
  logic [8:0]  a_eff;
  logic [23:0] a_len, a_wlen;
  logic [1:0]  a_cmd;
  logic [7:0]  a_data;
  logic        b_busy, b_fin, b_req, b_vld, b_urdy, b_urun;
  logic [8:0]  b_eff;
  logic [23:0] b_len, b_wlen;
  logic [1:0]  b_cmd;
  logic [7:0]  b_data;

  always #5 clk = ~clk;

  spi_prog_write #(.MODULE_ID(0), .CMD(0)) dut0 (
    .clock(clk), .rst(rst), .cmd_request(cmd_request), .cmd_code(cmd_code),
    .cmd_busy(a_busy), .cmd_finish(a_fin), .wr_addr(wr_addr), .wr_len(wr_len),
    .eff_len(a_eff), .spi_request(a_req), .spi_busy(spi_busy), .spi_clk_en(spi_clk_en),
    .spi_req_len(a_len), .spi_req_wr_len(a_wlen), .spi_req_cmd(a_cmd),
    .spi_wr_vld(a_vld), .spi_wr_ready(spi_wr_ready), .spi_wr_data(a_data),
    .up_valid(up_valid), .up_data(up_data), .up_ready(a_urdy), .underrun(a_urun));

  spi_prog_write #(.MODULE_ID(1), .CMD(1), .ADDR_BYTES(4), .SSIZE(4)) dut1 (
    .clock(clk), .rst(rst), .cmd_request(cmd_request), .cmd_code(cmd_code),
    .cmd_busy(b_busy), .cmd_finish(b_fin), .wr_addr(wr_addr), .wr_len(wr_len),
    .eff_len(b_eff), .spi_request(b_req), .spi_busy(spi_busy), .spi_clk_en(spi_clk_en),
    .spi_req_len(b_len), .spi_req_wr_len(b_wlen), .spi_req_cmd(b_cmd),
    .spi_wr_vld(b_vld), .spi_wr_ready(spi_wr_ready), .spi_wr_data(b_data),
    .up_valid(up_valid), .up_data(up_data), .up_ready(b_urdy), .underrun(b_urun));

  // Selected-instance view.
  bit          sel;
  logic        m_busy, m_fin, m_req, m_vld, m_urdy, m_urun;
  logic [8:0]  m_eff;
  logic [23:0] m_len, m_wlen;
  logic [7:0]  m_data;
  always_comb begin
    m_busy = sel ? b_busy : a_busy;
    m_fin  = sel ? b_fin  : a_fin;
    m_req  = sel ? b_req  : a_req;
    m_vld  = sel ? b_vld  : a_vld;
    m_urdy = sel ? b_urdy : a_urdy;
    m_urun = sel ? b_urun : a_urun;
    m_eff  = sel ? b_eff  : a_eff;
    m_len  = sel ? b_len  : a_len;
    m_wlen = sel ? b_wlen : a_wlen;
    m_data = sel ? b_data : a_data;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          sel;
    logic [31:0] addr;
    logic [8:0]  len;
    logic [8:0]  eff;
    logic [23:0] rlen;
    logic [7:0]  base;
    bit          gaps;
    bit          slow;
    bit          poke;
  } vec_t;

  // Expected k-th byte on the SPI write stream.
  function automatic logic [7:0] exp_byte(input bit s, input logic [31:0] a,
                                          input logic [7:0] base, input int k);
    int hb;
    hb = s ? 5 : 4;
    if (k == 0) return s ? 8'h12 : 8'h02;
    if (k < hb) return 8'(a >> (8 * (hb - 1 - k)));
    return base + 8'(k - hb);
  endfunction

  task automatic issue(input vec_t v);
    @(negedge clk);
    sel = v.sel; cmd_code = v.sel ? 8'd1 : 8'd0;
    wr_addr = v.addr; wr_len = v.len; cmd_request = 1'b1;
    @(negedge clk);
    cmd_request = 1'b0;
  endtask

  // Wait for the engine request, check latched lengths, raise spi_busy.
  task automatic grant(input vec_t v, output bit ok);
    int t;
    t = 0;
    #1;
    while (!m_req && t < 20) begin @(negedge clk); #1; t++; end
    ok = m_req;
    chk("spi_request_seen", 32'(m_req), 32'd1);
    if (!ok) return;
    chk("eff_len", 32'(m_eff), 32'(v.eff));
    chk("spi_req_len", m_len, 32'(v.rlen));
    chk("spi_req_wr_len", m_wlen, 32'(v.rlen));
    chk("busy_in_req", 32'(m_busy), 32'd1);
    spi_busy = 1'b1;
  endtask

  // Stream until stop_at bytes are accepted by the engine; ends on the negedge
  // after the last accepted byte.
  task automatic stream(input vec_t v, input int stop_at, output int got, output int beats);
    int cyc;
    got = 0; beats = 0; cyc = 0;
    while (got < stop_at && cyc < 5000) begin
      spi_clk_en   = v.slow ? ($urandom_range(0, 3) == 0) : 1'b1;
      spi_wr_ready = v.slow ? ($urandom_range(0, 3) != 0) : 1'b1;
      up_valid     = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      up_data      = v.base + 8'(beats);
      cmd_request  = (v.poke && cyc == 20);
      if (cmd_request) begin wr_addr = 32'hFF; wr_len = 9'd1; end
      #1;
      if (!m_vld) chk("data_zero_when_idle", 32'(m_data), 32'd0);
      if (m_vld && spi_wr_ready && spi_clk_en) begin
        chk($sformatf("byte%0d", got), 32'(m_data), 32'(exp_byte(v.sel, v.addr, v.base, got)));
        got++;
      end
      if (up_valid && m_urdy) beats++;
      @(negedge clk);
      cyc++;
    end
    cmd_request = 1'b0;
    chk("stream_done_in_time", 32'(got), 32'(stop_at));
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int got, beats, fins, nb;
    nb = (v.sel ? 5 : 4) + int'(v.eff);
    issue(v);
    grant(v, ok);
    if (!ok) return;
    stream(v, nb, got, beats);
    spi_busy = 1'b0; spi_clk_en = 1'b0; up_valid = 1'b0;
    fins = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (m_fin) fins++;
      if (m_vld || m_urdy) beats = beats + 1000;  // no activity after last byte
      @(negedge clk);
    end
    chk("finish_once", 32'(fins), 32'd1);
    chk("up_beats", 32'(beats), 32'(v.eff));
    chk("idle_after", 32'(m_busy), 32'd0);
    chk("eff_len_held", 32'(m_eff), 32'(v.eff));
  endtask

  vec_t vecs[7];

  initial begin
    bit ok;
    int got, beats;
    vec_t u;
    vecs[0] = '{1'b0, 32'h012300,   9'd256, 9'd256, 24'd2080, 8'h00, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 32'h0000F0,   9'd64,  9'd16,  24'd160,  8'h40, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 32'h01000000, 9'd8,   9'd8,   24'd26,   8'hA0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h000010,   9'd0,   9'd240, 24'd1952, 8'h11, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b0, 32'h0000FF,   9'd5,   9'd1,   24'd40,   8'h77, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 32'h000100,   9'd300, 9'd256, 24'd2080, 8'h05, 1'b1, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 32'h000000F8, 9'd20,  9'd8,   24'd26,   8'hC3, 1'b1, 1'b1, 1'b0};

    rst = 1'b1; cmd_request = 1'b0; cmd_code = 8'd0; wr_addr = '0; wr_len = '0;
    spi_busy = 1'b0; spi_clk_en = 1'b0; spi_wr_ready = 1'b1; up_valid = 1'b0;
    up_data = '0; sel = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'({a_busy, b_busy}), 32'd0);
    chk("rst_finish", 32'({a_fin, b_fin}), 32'd0);
    chk("rst_request", 32'({a_req, b_req}), 32'd0);
    chk("rst_vld", 32'({a_vld, b_vld}), 32'd0);
    chk("rst_len", a_len | b_len | a_wlen | b_wlen, 32'd0);
    chk("rst_eff", 32'(a_eff | b_eff), 32'd0);
    chk("rst_cmd", 32'({a_cmd, b_cmd}), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) run_vec(vecs[i]);

    // Engine drops busy after 10 data bytes: underrun pulse, then finish, then idle.
    u = '{1'b0, 32'h000200, 9'd32, 9'd32, 24'd288, 8'h60, 1'b0, 1'b0, 1'b0};
    issue(u);
    grant(u, ok);
    if (ok) begin
      stream(u, 14, got, beats);
      spi_busy = 1'b0; spi_clk_en = 1'b0; up_valid = 1'b0;
      #1;
      chk("underrun_pulse", 32'(m_urun), 32'd1);
      chk("underrun_no_finish_yet", 32'(m_fin), 32'd0);
      @(negedge clk); #1;
      chk("underrun_clears", 32'(m_urun), 32'd0);
      chk("finish_after_underrun", 32'(m_fin), 32'd1);
      chk("vld_dropped", 32'(m_vld), 32'd0);
      @(negedge clk); #1;
      chk("idle_after_underrun", 32'({m_busy, m_fin}), 32'd0);
    end

    // Reset while streaming: outputs low at once, no finish, then a clean command.
    u = '{1'b0, 32'h000300, 9'd32, 9'd32, 24'd288, 8'h90, 1'b0, 1'b0, 1'b0};
    issue(u);
    grant(u, ok);
    if (ok) begin
      stream(u, 10, got, beats);
      rst = 1'b1; spi_busy = 1'b0;
      #1;
      chk("mid_rst_ctrl", 32'({a_busy, a_fin, a_req, a_vld, a_urdy, a_urun}), 32'd0);
      chk("mid_rst_data", 32'(a_data), 32'd0);
      chk("mid_rst_len", a_len | a_wlen, 32'd0);
      chk("mid_rst_eff", 32'(a_eff), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("post_rst_idle", 32'({a_busy, a_fin, a_vld}), 32'd0);
      @(negedge clk); #1;
      chk("post_rst_no_finish", 32'(a_fin), 32'd0);
    end
    run_vec(vecs[1]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_prog_write.md
SPI_PROG_WRITE -- requirements
Module: spi_prog_write

Interface
REQ-001 Parameters, one per line (name, default, meaning):
- MODULE_ID, 0, bit index this block drives in cmd_busy/cmd_finish.
- CMD, 0, command code this block answers on cmd_code.
- DSIZE, 8, bits per transferred byte.
- ADDR_BYTES, 3, address bytes sent (legal 3 or 4).
- MAX_BURST, 256, largest data burst in bytes (power of 2).
- PAGE_SIZE, 256, flash page size in bytes (power of 2, >= MAX_BURST).
- PRG_CMD_3B, 8'h02, opcode used when ADDR_BYTES=3.
- PRG_CMD_4B, 8'h12, opcode used when ADDR_BYTES=4.
- SSIZE, 1, data lanes (1, 2 or 4); divides length in SPI clocks.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock.
- rst, in, 1, synchronous active-high reset.
- cmd_request, in, 1, command strobe.
- cmd_code, in, 8, command selector.
- cmd_busy, out, 1, bit MODULE_ID of the shared busy vector.
- cmd_finish, out, 1, bit MODULE_ID of the shared finish vector.
- wr_addr, in, 32, flash byte address (low 8*ADDR_BYTES bits used).
- wr_len, in, 9+, requested data bytes, 1..MAX_BURST (width clog2(MAX_BURST)+1).
- eff_len, out, same width as wr_len, data bytes actually programmed.
- spi_request, out, 1, engine request.
- spi_busy, in, 1, engine busy.
- spi_clk_en, in, 1, engine byte-slot enable.
- spi_req_len, out, 24, total transfer length in SPI clocks.
- spi_req_wr_len, out, 24, write-phase length in SPI clocks.
- spi_req_cmd, out, 2, engine command; constant 0.
- spi_wr_vld, out, 1, byte valid to engine.
- spi_wr_ready, in, 1, engine ready.
- spi_wr_data, out, DSIZE, byte to engine.
- up_valid, in, 1, upstream data valid.
- up_data, in, DSIZE, upstream data.
- up_ready, out, 1, upstream ready.
- underrun, out, 1, one-cycle error pulse.
REQ-003 The design SHALL use one clock with a synchronous active-high reset named rst.

Function
REQ-004 Control FSM states SHALL be IDLE, LATCH, EX_REQ, EXEC, DRAIN, FSH.
REQ-005 IDLE->LATCH on cmd_request && cmd_code==CMD; wr_addr and wr_len are captured in that same cycle.
REQ-006 LATCH SHALL last 1 cycle and compute eff_len = min(wr_len, PAGE_SIZE - (addr mod PAGE_SIZE)); wr_len of 0 or above MAX_BURST is clamped to MAX_BURST before the page clip.
REQ-007 LATCH SHALL register spi_req_len = spi_req_wr_len = (1+ADDR_BYTES+eff_len)*8/SSIZE; both hold until the next LATCH.
REQ-008 EX_REQ SHALL drive spi_request=1 until spi_busy=1, then go to EXEC.
REQ-009 EXEC SHALL send bytes in this order: opcode, address MSB first, then eff_len data bytes.
REQ-010 A byte SHALL transfer only in a cycle where spi_wr_vld && spi_wr_ready && spi_clk_en.
REQ-011 EXEC->DRAIN after the last data byte transfers; DRAIN->FSH when spi_busy=0; FSH->IDLE after 1 cycle.
REQ-012 Output register: header bytes are loaded with spi_wr_vld=1 regardless of up_valid.
REQ-013 In the data phase the output register SHALL reload from up_data when it is empty or being consumed.
REQ-014 up_ready = data phase && bytes remaining to fetch > 0 && (register empty || transfer this cycle); no more than eff_len beats SHALL be accepted.
REQ-015 spi_wr_data SHALL be zero whenever spi_wr_vld=0.
REQ-016 cmd_busy SHALL be 1 in LATCH, EX_REQ, EXEC and DRAIN; cmd_finish SHALL be 1 only in FSH.
REQ-017 If spi_busy falls in EXEC before all bytes are sent, the block SHALL pulse underrun for 1 cycle, discard the output register, and go to FSH.
REQ-018 cmd_request while not in IDLE SHALL be ignored.
REQ-019 Address arithmetic SHALL use the low log2(PAGE_SIZE) address bits; crossing the page boundary is never allowed.

Reset
REQ-020 While rst=1, at the next clock edge the FSM SHALL go to IDLE.
REQ-021 While rst=1, cmd_busy, cmd_finish, spi_request, spi_wr_vld, up_ready and underrun SHALL be 0.
REQ-022 While rst=1, spi_wr_data, spi_req_len, spi_req_wr_len and eff_len SHALL be 0.
REQ-023 Reset mid-transfer SHALL abort the transfer without asserting finish.

Verification
REQ-024 ADDR_BYTES=3, addr 0x012300, len 256, upstream always valid -> bytes 02 01 23 00 then 256 data bytes; spi_req_len=2080; finish pulses once.
REQ-025 Addr 0x0000F0, len 64 -> eff_len=16, spi_req_len=160, exactly 16 up beats accepted.
REQ-026 ADDR_BYTES=4, SSIZE=4, addr 0x01000000, len 8 -> header 12 01 00 00 00; spi_req_len=26.
REQ-027 Random up_valid gaps and spi_clk_en at 1/4 duty -> data order preserved; no beat lost or duplicated.
REQ-028 spi_busy dropped after 10 data bytes -> underrun=1 for 1 cycle, finish next, FSM back in IDLE.
REQ-029 rst asserted in EXEC -> all outputs 0 next cycle; a new command then completes normally.
